// File: rtl/branch_pkg.sv
// branch_pkg: shared types and constants for the branch resolve queue.
package branch_pkg;
    // Entries hold PCs at a fixed maximum width; narrower PC_W values are zero-extended.
    localparam int PC_MAX  = 64;
    localparam int PC_STEP = 4;
    typedef enum logic {RUN, FLUSH} brq_state_t;
    typedef struct packed {
        logic [PC_MAX-1:0] pc;
        logic              pred_taken;
        logic [PC_MAX-1:0] pred_target;
    } brq_entry_t;
endpackage

// File: rtl/brq_fifo.sv
// brq_fifo: circular buffer of in-flight branch entries with push, pop, clear and occupancy count.
module brq_fifo
    import branch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clear,
    input  brq_entry_t                   wdata,
    output brq_entry_t                   rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    brq_entry_t mem [DEPTH];
    logic [AW-1:0] wp, rp;
    assign rdata = mem[rp];
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wp] <= wdata;
                wp      <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order in-flight branch queue driving predictor training and mispredict flush.
// Optional BRQ_STATS_EN adds saturating resolve/mispredict counters.
module branch_resolve_queue
    import branch_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PC_W  = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push_valid,
    output logic                         push_ready,
    input  logic [PC_W-1:0]              push_pc,
    input  logic                         push_pred_taken,
    input  logic [PC_W-1:0]              push_pred_target,
    input  logic                         resolve_valid,
    input  logic                         resolve_taken,
    input  logic [PC_W-1:0]              resolve_target,
    output logic                         upd_valid,
    output logic                         upd_taken,
    output logic                         flush,
    output logic [PC_W-1:0]              redirect_pc,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef BRQ_STATS_EN
    ,
    output logic [31:0]                  stat_resolved,
    output logic [31:0]                  stat_mispredict
`endif
);
    localparam int CW = $clog2(DEPTH+1);
    brq_state_t state_q, state_d;
    brq_entry_t head, wentry;
    logic push_acc, res_acc, mispredict, squash;
    logic [PC_MAX-1:0] correct_pc;

    assign push_ready = state_q == RUN && count < CW'(DEPTH);
    assign empty      = count == '0;
    assign push_acc   = push_valid && push_ready;
    assign res_acc    = resolve_valid && state_q == RUN && !empty;
    assign squash     = res_acc && mispredict;
    assign wentry     = '{pc: PC_MAX'(push_pc), pred_taken: push_pred_taken,
                          pred_target: PC_MAX'(push_pred_target)};

    always_comb begin
        mispredict = head.pred_taken != resolve_taken ||
                     (resolve_taken && head.pred_target != PC_MAX'(resolve_target));
        correct_pc = resolve_taken ? PC_MAX'(resolve_target) : head.pc + PC_MAX'(PC_STEP);
        state_d    = squash ? FLUSH : RUN;
    end

    // A mispredict drops the whole queue, including any same-cycle push.
    brq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_acc && !squash),
        .pop     (res_acc && !mispredict),
        .clear   (squash),
        .wdata   (wentry),
        .rdata   (head),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        state_q <= !reset_n ? RUN : state_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            upd_valid   <= 1'b0;
            upd_taken   <= 1'b0;
            flush       <= 1'b0;
            redirect_pc <= '0;
        end else begin
            upd_valid <= res_acc;
            upd_taken <= res_acc && resolve_taken;
            flush     <= squash;
            if (squash) redirect_pc <= PC_W'(correct_pc);
        end
    end

`ifdef BRQ_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_resolved   <= '0;
            stat_mispredict <= '0;
        end else begin
            if (res_acc && stat_resolved != '1) stat_resolved <= stat_resolved + 1'b1;
            if (squash && stat_mispredict != '1) stat_mispredict <= stat_mispredict + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: directed and randomized checks against a queue-based reference model.
module tb_branch_resolve_queue;
    localparam int DEPTH = 8;
    typedef struct {
        logic [31:0] pc;
        bit          pt;
        logic [31:0] tg;
    } ent_t;

    logic clk = 0, reset_n = 0;
    logic push_valid = 0, push_pred_taken = 0, resolve_valid = 0, resolve_taken = 0;
    logic [31:0] push_pc = 0, push_pred_target = 0, resolve_target = 0;
    logic push_ready, upd_valid, upd_taken, flush, empty;
    logic [31:0] redirect_pc;
    logic [3:0] count;
`ifdef BRQ_STATS_EN
    logic [31:0] stat_resolved, stat_mispredict;
`endif

    branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc),
        .push_pred_taken(push_pred_taken), .push_pred_target(push_pred_target),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target),
        .upd_valid(upd_valid), .upd_taken(upd_taken), .flush(flush),
        .redirect_pc(redirect_pc), .empty(empty), .count(count)
`ifdef BRQ_STATS_EN
        , .stat_resolved(stat_resolved), .stat_mispredict(stat_mispredict)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    ent_t m_q[$];
    bit m_fl;
    bit e_upd_valid, e_upd_taken, e_flush;
    logic [31:0] e_redirect;
    int unsigned e_res, e_mis;

    function automatic bit exp_ready();
        return !m_fl && m_q.size() < DEPTH;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_fl = 0;
        e_upd_valid = 0;
        e_upd_taken = 0;
        e_flush = 0;
        e_redirect = 0;
        e_res = 0;
        e_mis = 0;
    endtask

    // One clock: drive inputs, advance the model, sample outputs 1ns after the edge.
    task automatic step(input bit pv, input logic [31:0] pc, input bit pt, input logic [31:0] tg,
                        input bit rv, input bit rt, input logic [31:0] rtg);
        bit rdy, racc, mis;
        ent_t h;
        push_valid = pv; push_pc = pc; push_pred_taken = pt; push_pred_target = tg;
        resolve_valid = rv; resolve_taken = rt; resolve_target = rtg;
        rdy = exp_ready();
        racc = rv && !m_fl && m_q.size() != 0;
        mis = 0;
        e_upd_valid = racc;
        e_upd_taken = racc && rt;
        e_flush = 0;
        if (racc) begin
            h = m_q[0];
            mis = (h.pt != rt) || (rt && h.tg != rtg);
            e_res++;
        end
        if (mis) begin
            m_q.delete();
            e_flush = 1;
            e_redirect = rt ? rtg : h.pc + 32'd4;
            e_mis++;
        end else begin
            if (racc) void'(m_q.pop_front());
            if (pv && rdy) m_q.push_back('{pc, pt, tg});
        end
        m_fl = mis;
        @(posedge clk);
        #1;
        push_valid = 0;
        resolve_valid = 0;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic resolve_ok();
        step(0, 0, 0, 0, 1, m_q[0].pt, m_q[0].tg);
    endtask

    task automatic do_reset();
        reset_n = 0;
        @(posedge clk);
        #1;
        reset_n = 1;
        push_valid = 0;
        resolve_valid = 0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (count !== 0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        n_checks++; if (empty !== 1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", empty); end
        n_checks++; if (push_ready !== 1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", push_ready); end
        n_checks++; if (upd_valid !== 0 || upd_taken !== 0) begin n_fail++; $display("FAIL reset_upd got %b%b exp 00", upd_valid, upd_taken); end
        n_checks++; if (flush !== 0 || redirect_pc !== 0) begin n_fail++; $display("FAIL reset_flush got %b/%h exp 0/0", flush, redirect_pc); end
    endtask

    task automatic test_correct_nt();
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 32'h10 * (i + 1), 0, 32'h900, 0, 0, 0);
        n_checks++; if (count !== 3) begin n_fail++; $display("FAIL nt_fill got %0d exp 3", count); end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1, 0, 0);
            n_checks++;
            if (upd_valid !== 1 || upd_taken !== 0 || flush !== 0 || count !== 4'(2 - i)) begin
                n_fail++;
                $display("FAIL nt_resolve%0d got uv=%b ut=%b fl=%b cnt=%0d exp 1 0 0 %0d", i, upd_valid, upd_taken, flush, count, 2 - i);
            end
        end
        idle();
        n_checks++; if (upd_valid !== 0 || empty !== 1) begin n_fail++; $display("FAIL nt_after got uv=%b empty=%b exp 0 1", upd_valid, empty); end
    endtask

    task automatic test_mispredict();
        do_reset();
        step(1, 32'h100, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 32'h200);
        n_checks++;
        if (flush !== 1 || redirect_pc !== 32'h200 || upd_valid !== 1 || upd_taken !== 1 || count !== 0 || push_ready !== 0) begin
            n_fail++;
            $display("FAIL mp_dir got fl=%b pc=%h uv=%b ut=%b cnt=%0d rdy=%b exp 1 200 1 1 0 0", flush, redirect_pc, upd_valid, upd_taken, count, push_ready);
        end
        idle();
        n_checks++;
        if (flush !== 0 || push_ready !== 1 || redirect_pc !== 32'h200) begin
            n_fail++;
            $display("FAIL mp_after got fl=%b rdy=%b pc=%h exp 0 1 200", flush, push_ready, redirect_pc);
        end
        step(1, 32'h100, 1, 32'h180, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 32'h1C0);
        n_checks++; if (flush !== 1 || redirect_pc !== 32'h1C0) begin n_fail++; $display("FAIL mp_target got fl=%b pc=%h exp 1 1c0", flush, redirect_pc); end
        idle();
        step(1, 32'h100, 1, 32'h180, 0, 0, 0);
        step(1, 32'h300, 0, 0, 1, 0, 0);
        n_checks++;
        if (flush !== 1 || redirect_pc !== 32'h104 || count !== 0 || upd_taken !== 0) begin
            n_fail++;
            $display("FAIL mp_nt got fl=%b pc=%h cnt=%0d ut=%b exp 1 104 0 0", flush, redirect_pc, count, upd_taken);
        end
        step(1, 32'h400, 0, 0, 1, 0, 0);
        n_checks++; if (count !== 0 || upd_valid !== 0) begin n_fail++; $display("FAIL flush_ignore got cnt=%0d uv=%b exp 0 0", count, upd_valid); end
        idle();
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, 32'h1000 + 32'(i) * 8, 0, 0, 0, 0, 0);
        n_checks++; if (push_ready !== 0 || count !== 8) begin n_fail++; $display("FAIL full got rdy=%b cnt=%0d exp 0 8", push_ready, count); end
        step(1, 32'h2000, 0, 0, 1, 0, 0);
        n_checks++; if (count !== 7 || flush !== 0) begin n_fail++; $display("FAIL full_pushpop got cnt=%0d fl=%b exp 7 0", count, flush); end
        for (int i = 0; i < 3; i++) resolve_ok();
        step(1, 32'h3000, 0, 0, 1, m_q[0].pt, m_q[0].tg);
        n_checks++; if (count !== 4) begin n_fail++; $display("FAIL mid_pushpop got cnt=%0d exp 4", count); end
        while (m_q.size() != 0) begin
            resolve_ok();
            n_checks++; if (flush !== 0 || count !== 4'(m_q.size())) begin n_fail++; $display("FAIL drain got fl=%b cnt=%0d exp 0 %0d", flush, count, m_q.size()); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step(1, 32'h500, 1, 32'h5f0, 0, 0, 0);
        step(1, 32'h504, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, $urandom & 32'hffff_fffc, 1'($urandom), $urandom, 1, m_q[0].pt, m_q[0].tg);
            n_checks++;
            if (flush !== 0 || upd_valid !== 1 || count !== 2) begin
                n_fail++;
                $display("FAIL wrap%0d got fl=%b uv=%b cnt=%0d exp 0 1 2", i, flush, upd_valid, count);
            end
        end
    endtask

    task automatic test_empty_resolve();
        do_reset();
        step(0, 0, 0, 0, 1, 1, 32'h77);
        n_checks++; if (upd_valid !== 0 || flush !== 0 || count !== 0) begin n_fail++; $display("FAIL empty_resolve got uv=%b fl=%b cnt=%0d exp 0 0 0", upd_valid, flush, count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 32'h600 + 32'(i) * 4, 0, 0, 0, 0, 0);
        resolve_valid = 1; resolve_taken = 1; resolve_target = 32'h999;
        do_reset();
        n_checks++;
        if (count !== 0 || flush !== 0 || upd_valid !== 0 || push_ready !== 1) begin
            n_fail++;
            $display("FAIL reset_mid got cnt=%0d fl=%b uv=%b rdy=%b exp 0 0 0 1", count, flush, upd_valid, push_ready);
        end
    endtask

    task automatic test_random();
        bit rv, good;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom % 3) != 0;
            good = ($urandom % 4) != 0;
            if (rv && good && m_q.size() != 0)
                step(($urandom % 3) != 0, $urandom, 1'($urandom), $urandom, 1, m_q[0].pt, m_q[0].tg);
            else
                step(($urandom % 3) != 0, $urandom, 1'($urandom), $urandom & 32'hf, rv, 1'($urandom), $urandom & 32'hf);
            n_checks++;
            if (count !== 4'(m_q.size()) || empty !== (m_q.size() == 0) || push_ready !== exp_ready() ||
                upd_valid !== e_upd_valid || upd_taken !== e_upd_taken || flush !== e_flush || redirect_pc !== e_redirect) begin
                n_fail++;
                $display("FAIL rand%0d got cnt=%0d rdy=%b uv=%b ut=%b fl=%b pc=%h exp %0d %b %b %b %b %h", i,
                         count, push_ready, upd_valid, upd_taken, flush, redirect_pc,
                         m_q.size(), exp_ready(), e_upd_valid, e_upd_taken, e_flush, e_redirect);
            end
        end
    endtask

    task automatic test_stats();
`ifdef BRQ_STATS_EN
        do_reset();
        n_checks++; if (stat_resolved !== 0 || stat_mispredict !== 0) begin n_fail++; $display("FAIL stats_reset got %0d %0d exp 0 0", stat_resolved, stat_mispredict); end
        for (int i = 0; i < 5; i++) begin
            step(1, 32'h700 + 32'(i) * 4, 0, 0, 0, 0, 0);
            step(0, 0, 0, 0, 1, i == 1 || i == 3, 32'h800);
            idle();
        end
        n_checks++; if (stat_resolved !== 5 || stat_mispredict !== 2) begin n_fail++; $display("FAIL stats got %0d %0d exp 5 2", stat_resolved, stat_mispredict); end
        n_checks++; if (stat_resolved !== e_res || stat_mispredict !== e_mis) begin n_fail++; $display("FAIL stats_model got %0d %0d exp %0d %0d", stat_resolved, stat_mispredict, e_res, e_mis); end
`endif
    endtask

    initial begin
        model_reset();
        test_reset();
        test_correct_nt();
        test_mispredict();
        test_full();
        test_wrap();
        test_empty_resolve();
        test_reset_mid();
        test_random();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

In-order queue of in-flight conditional branches, sitting between fetch (where the pattern-history predictor's `prediction` is sampled) and execute (where the branch resolves). Fetch pushes each predicted branch with its PC, predicted direction and predicted target. Execute resolves branches oldest-first. The block then drives the predictor's training strobe (`valid` and `actual_branch_taken`) and, on a misprediction, a one-cycle pipeline flush with the corrected fetch PC.

## Interface
Parameters:
- DEPTH, 8, number of queue entries; power of two, ≥2
- PC_W, 32, PC width

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- push_valid  in  1  fetch presents a conditional branch
- push_ready  out  1  queue can accept a push this cycle
- push_pc  in  PC_W  branch PC
- push_pred_taken  in  1  predictor output sampled at fetch
- push_pred_target  in  PC_W  target fetch used if predicted taken
- resolve_valid  in  1  execute resolved the oldest branch
- resolve_taken  in  1  actual direction
- resolve_target  in  PC_W  actual taken target
- upd_valid  out  1  training strobe to predictor `valid`
- upd_taken  out  1  to predictor `actual_branch_taken`
- flush  out  1  squash younger work, redirect fetch
- redirect_pc  out  PC_W  corrected fetch PC, valid while flush=1
- empty  out  1  no entries
- count  out  $clog2(DEPTH+1)  occupancy

## Operation
- State machine RUN/FLUSH; reset → RUN, count=0.
- Push accepted when push_valid && push_ready; push_ready = (state==RUN) && (count<DEPTH). A full queue never accepts a push, even if a pop happens in the same cycle.
- Resolve accepted when resolve_valid && state==RUN && !empty; it pops the head. resolve_valid while empty or in FLUSH is ignored, with no side effects.
- Mispredict = (head.pred_taken != resolve_taken) || (resolve_taken && head.pred_target != resolve_target).
- Correct PC = resolve_taken ? resolve_target : head.pc + 4 (modulo 2^PC_W).
- Accepted resolve, no mispredict: pop head; a simultaneous push is also accepted (count unchanged).
- Accepted resolve with mispredict: all entries cleared and any same-cycle push discarded (count→0). Next state is FLUSH.
- FLUSH: lasts exactly one cycle, then returns to RUN. push_ready=0 and resolves are ignored.
- Read/write pointers wrap modulo DEPTH.

## Timing
- Reset values: push_ready=1 (after the reset cycle), upd_valid=0, upd_taken=0, flush=0, redirect_pc=0, empty=1, count=0.
- Reset mid-operation drops all entries and pending strobes on the same edge.
- upd_valid/upd_taken are registered: they pulse one cycle after every accepted resolve, mispredicted or not.
- flush/redirect_pc are registered: flush pulses one cycle after the mispredicting resolve, coincident with upd_valid. redirect_pc holds its value until the next flush.
- push_ready, empty and count are derived from registered state only; there are no combinational paths from inputs to outputs.
- Push-to-resolvable latency: an entry pushed in cycle N is resolvable in cycle N+1.

## Configuration
- BRQ_STATS_EN defined: adds outputs stat_resolved and stat_mispredict (32-bit each).
  - Both count accepted resolves / mispredicts and saturate at 2^32−1.
  - Both reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- Shared package branch_pkg:
  - brq_entry_t struct {pc, pred_taken, pred_target}
  - brq_state_t enum {RUN, FLUSH}
  - constant PC_STEP = 4
- Sub-module brq_fifo: circular buffer of brq_entry_t with push, pop, clear and count. The top level holds the state machine, compare logic and output registers.

## Test plan
- Reset, push 3 branches (pred NT), resolve each NT → upd_valid pulses 3×, upd_taken=0, flush never asserts, count 3→0.
- Push PC=0x100 pred NT; resolve taken, target 0x200 → next cycle flush=1, redirect_pc=0x200, upd_taken=1; count=0; push_ready=0 for that one cycle.
- Push PC=0x100 pred T, target 0x180; resolve taken, target 0x1C0 → flush=1, redirect_pc=0x1C0.
- Push PC=0x100 pred T; resolve NT → redirect_pc=0x104. With a push asserted in the resolve cycle, that push is discarded and count=0.
- Fill to DEPTH=8 → push_ready=0. Push+resolve in the same cycle → push rejected, count=7. Push+resolve at count=4 → count stays 4. Run 20 pushes/resolves to exercise pointer wrap-around with FIFO order preserved.
- resolve_valid while empty → no upd_valid. Assert reset_n=0 with 5 entries → count=0, flush=0. With BRQ_STATS_EN, 2 mispredicts in 5 resolves → stat_resolved=5, stat_mispredict=2.
